// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: funct3 codes, ex_kind
// encodings, FSM states and the pending-access payload.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned KIND_W = 2;
  localparam int unsigned STRB_W = XLEN / 8;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;
  localparam logic [F3_W-1:0] F3_SB  = 3'b000;
  localparam logic [F3_W-1:0] F3_SH  = 3'b001;
  localparam logic [F3_W-1:0] F3_SW  = 3'b010;

  typedef enum logic [KIND_W-1:0] {
    KIND_ALU     = 2'b00,
    KIND_LOAD    = 2'b01,
    KIND_STORE   = 2'b10,
    KIND_ALU_ALT = 2'b11
  } ex_kind_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } acc_size_e;

  // Access captured at handshake and consumed when the memory acks.
  typedef struct packed {
    logic [F3_W-1:0] funct3;
    logic [1:0]      addr_lo;
    logic [RD_W-1:0] rd;
    logic            load;
  } lsu_pend_t;

  // Reserved funct3 encodings (011, 110, 111) fall through to word size.
  function automatic acc_size_e size_of(input logic [F3_W-1:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [F3_W-1:0] f3, input logic [1:0] a);
    case (size_of(f3))
      SZ_HALF: return a[0];
      SZ_WORD: return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side, data-memory and register-file write ports of the load/store unit.
// master = the LSU itself, slave = its surroundings (execute, memory, regfile).
interface load_store_unit_if
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
);

  logic              ex_valid;
  logic              ex_ready;
  logic [KIND_W-1:0] ex_kind;
  logic [F3_W-1:0]   ex_funct3;
  logic [RD_W-1:0]   ex_rd;
  logic [XLEN-1:0]   ex_alu;
  logic [XLEN-1:0]   ex_sdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  logic [RD_W-1:0]   wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              wb_valid;
  logic              misalign;

  modport master (
    input  ex_valid, ex_kind, ex_funct3, ex_rd, ex_alu, ex_sdata,
    input  mem_ack, mem_rdata,
    output ex_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output wb_rd, wb_data, wb_valid, misalign
  );

  modport slave (
    output ex_valid, ex_kind, ex_funct3, ex_rd, ex_alu, ex_sdata,
    output mem_ack, mem_rdata,
    input  ex_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  wb_rd, wb_data, wb_valid, misalign
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data/strobe generation and load
// byte/half extraction with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [F3_W-1:0]   st_funct3,
  input  logic [1:0]        st_addr_lo,
  input  logic [XLEN-1:0]   st_data,
  output logic [XLEN-1:0]   st_wdata_c,
  output logic [STRB_W-1:0] st_wstrb_c,
  input  logic [F3_W-1:0]   ld_funct3,
  input  logic [1:0]        ld_addr_lo,
  input  logic [XLEN-1:0]   ld_rdata,
  output logic [XLEN-1:0]   ld_data_c
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;

  // Narrow stores are replicated so the addressed lanes carry the data.
  always_comb begin
    st_wdata_c = st_data;
    st_wstrb_c = 4'b1111;
    case (size_of(st_funct3))
      SZ_BYTE: begin
        st_wdata_c = {4{st_data[7:0]}};
        st_wstrb_c = 4'b0001 << st_addr_lo;
      end
      SZ_HALF: begin
        st_wdata_c = {2{st_data[15:0]}};
        st_wstrb_c = st_addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // funct3[2] clear selects the sign-extending LB/LH forms.
  always_comb begin
    ld_byte   = ld_rdata[5'({ld_addr_lo, 3'b000}) +: 8];
    ld_half   = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_signed = ~ld_funct3[2];
    ld_data_c = ld_rdata;
    case (size_of(ld_funct3))
      SZ_BYTE: ld_data_c = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data_c = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory/writeback stage: forwards ALU results or runs one load/store over
// a req/ack port, then pulses the register-file write. Option: LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input logic                clk,
  input logic                rst,
  load_store_unit_if.master  bus
);

  lsu_state_e        state_q, state_d;
  lsu_pend_t         pend_q, pend_d;
  logic              ex_ready_q, ex_ready_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              wb_valid_q, wb_valid_d;
  logic              misalign_q, misalign_d;

  logic              is_mem_op;
  logic              is_store;
  logic              go_mem;
  logic [XLEN-1:0]   st_wdata_c;
  logic [STRB_W-1:0] st_wstrb_c;
  logic [XLEN-1:0]   ld_data_c;

  assign is_mem_op = (bus.ex_kind == KIND_LOAD) || (bus.ex_kind == KIND_STORE);
  assign is_store  = (bus.ex_kind == KIND_STORE);

  lsu_lane_align u_lane_align (
    .st_funct3  (bus.ex_funct3),
    .st_addr_lo (bus.ex_alu[1:0]),
    .st_data    (bus.ex_sdata),
    .st_wdata_c (st_wdata_c),
    .st_wstrb_c (st_wstrb_c),
    .ld_funct3  (pend_q.funct3),
    .ld_addr_lo (pend_q.addr_lo),
    .ld_rdata   (bus.mem_rdata),
    .ld_data_c  (ld_data_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      ex_ready_q  <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      ex_ready_q  <= ex_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_valid_q  <= wb_valid_d;
      misalign_q  <= misalign_d;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_valid_d  = 1'b0;
    misalign_d  = 1'b0;
    go_mem      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.ex_valid && ex_ready_q) begin
          if (is_mem_op) begin
`ifdef LSU_MISALIGN_TRAP_EN
            if (is_misaligned(bus.ex_funct3, bus.ex_alu[1:0])) begin
              misalign_d = 1'b1;
            end else begin
              go_mem = 1'b1;
            end
`else
            go_mem = 1'b1;
`endif
          end else begin
            wb_rd_d    = bus.ex_rd;
            wb_data_d  = bus.ex_alu;
            wb_valid_d = (bus.ex_rd != '0);
          end
        end
      end
      ST_MEM: begin
        if (bus.mem_ack) begin
          state_d     = ST_IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = '0;
          if (pend_q.load) begin
            wb_rd_d    = pend_q.rd;
            wb_data_d  = ld_data_c;
            wb_valid_d = (pend_q.rd != '0);
          end
        end
      end
    endcase

    // Lane steering is resolved at acceptance so the bus stays stable while waiting.
    if (go_mem) begin
      state_d        = ST_MEM;
      mem_req_d      = 1'b1;
      mem_we_d       = is_store;
      mem_addr_d     = ADDR_W'({bus.ex_alu[XLEN-1:2], 2'b00});
      mem_wdata_d    = is_store ? st_wdata_c : XLEN'(0);
      mem_wstrb_d    = is_store ? st_wstrb_c : STRB_W'(0);
      pend_d.funct3  = bus.ex_funct3;
      pend_d.addr_lo = bus.ex_alu[1:0];
      pend_d.rd      = bus.ex_rd;
      pend_d.load    = ~is_store;
    end

    ex_ready_d = (state_d == ST_IDLE);
  end

  assign bus.ex_ready  = ex_ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.misalign  = misalign_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory/writeback stage of the RV32I core, sitting directly upstream of the register file. It accepts one instruction at a time from execute and either forwards an ALU result or performs a load/store through a req/ack data-memory port. It then drives the register-file write port (`wb_rd`, `wb_data`, `wb_valid`) with a registered one-cycle write pulse.

## Interface
Parameters:
- `ADDR_W`, default 32: data address width; `mem_addr` is always word-aligned.

Ports:
- `clk` in 1: core clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `ex_valid` in 1: execute presents an instruction.
- `ex_ready` out 1: stage can accept; high only in IDLE.
- `ex_kind` in 2: 00 ALU, 01 LOAD, 10 STORE, 11 treated as ALU.
- `ex_funct3` in 3: RV32I load/store size code (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `ex_rd` in 5: destination register.
- `ex_alu` in 32: ALU result, or effective address for LOAD/STORE.
- `ex_sdata` in 32: store data (rs2 value).
- `mem_req` out 1: memory request, held until ack.
- `mem_we` out 1: 1 for store.
- `mem_addr` out `ADDR_W`: `{addr[ADDR_W-1:2], 2'b00}`.
- `mem_wdata` out 32: store data replicated into the addressed lanes.
- `mem_wstrb` out 4: byte-lane enables; 0000 on loads.
- `mem_ack` in 1: one-cycle completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: load data word.
- `wb_rd` out 5, `wb_data` out 32, `wb_valid` out 1: register-file write port.
- `misalign` out 1: one-cycle pulse on a misaligned access (only when `LSU_MISALIGN_TRAP_EN` is defined).

## Operation
- FSM states: IDLE, MEM.
  - IDLE plus handshake (`ex_valid && ex_ready`) with an ALU op: capture `ex_rd`/`ex_alu` into the wb registers; stay in IDLE.
  - IDLE plus handshake with a LOAD or STORE that is aligned: register address, size, rd and data; go to MEM.
  - MEM: `mem_req`=1 with stable `mem_we`/`mem_addr`/`mem_wdata`/`mem_wstrb` until `mem_ack`.
  - MEM on `mem_ack`: return to IDLE. For a load, the extended data is written to the wb registers on that same edge.
- Store lanes:
  - SB: `wstrb` = 0001 shifted left by `addr[1:0]`; wdata = byte replicated ×4.
  - SH: `wstrb` = 0011 when `addr[1]`=0, else 1100; wdata = half replicated ×2.
  - SW: `wstrb` = 1111.
- Load extraction:
  - Select the byte or half by `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Undefined funct3 values (011, 110, 111) are handled as LW/SW.
- Writeback:
  - `wb_valid` pulses for ALU results and loads only.
  - A store never writes back.
  - `wb_valid` is suppressed when rd = 0.
- Alignment:
  - Misaligned means: half with `addr[0]`=1, or word with `addr[1:0]`≠00.
  - Behaviour is set by the `LSU_MISALIGN_TRAP_EN` configuration below.
- `mem_ack` arriving in IDLE is ignored.

## Timing
- Reset values: `ex_ready`=1, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `wb_rd`=0, `wb_data`=0, `wb_valid`=0, `misalign`=0, state IDLE.
- ALU op accepted at edge N: `wb_valid` is high during cycle N+1. Back-to-back ALU ops sustain one per cycle.
- LOAD/STORE accepted at edge N: `mem_req` is high from cycle N+1.
- With `mem_ack` in cycle M: `mem_req` and `wb_wstrb`... more precisely, `mem_req` drops and `mem_wstrb`/`mem_we` return to 0 in cycle M+1; `wb_valid` (load) and `ex_ready` are high in cycle M+1.
- Minimum load latency (ack in N+1): write pulse in N+2.
- `wb_valid` and `misalign` are single-cycle pulses, deasserted unless re-triggered.
- Reset asserted mid-MEM: `mem_req` drops asynchronously; the pending access is abandoned with no writeback; a late ack after reset release is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned LOAD/STORE is accepted and consumed in IDLE.
  - `misalign` pulses in the next cycle.
  - No memory request and no writeback; FSM stays IDLE.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - `misalign` is tied 0.
  - Low address bits below the access size are ignored: half uses `addr[1]`, word uses the aligned word.
  - The access proceeds normally.

## Structure
- Shared package `lsu_pkg`:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - `ex_kind` encodings.
  - FSM state encoding.
- Sub-module `lsu_lane_align`:
  - Combinational.
  - Store lane/strobe generation and load byte/half extraction with sign/zero extension.
  - Instantiated once; the FSM and registers stay in `load_store_unit`.

## Test plan
- ALU op, rd=5, alu=0x1234_5678, accepted at edge N: `wb_valid`=1, `wb_rd`=5, `wb_data`=0x1234_5678 in cycle N+1. A second op with rd=0 gives no `wb_valid`.
- LB, addr=0x0000_1003, rdata=0x80FF_FF7F, ack after 3 wait cycles: `mem_addr`=0x0000_1000, `wstrb`=0000; `wb_data`=0xFFFF_FF80 the cycle after ack. The same access as LBU gives 0x0000_0080.
- SH, addr=0x0000_2002, sdata=0xDEAD_BEEF: `mem_we`=1, `wstrb`=1100, `wdata`=0xBEEF_BEEF, held stable until ack; no `wb_valid`; `ex_ready`=1 the cycle after ack.
- LW, addr=0x0000_3001: with macro, `misalign`=1 for one cycle, `mem_req` never asserts, no writeback. Without macro, `mem_addr`=0x0000_3000 and the load completes.
- Reset pulled low while in MEM waiting on ack: `mem_req`=0 immediately and all outputs at reset values. An ack after reset release produces no `wb_valid`.
